// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues imem reads and
// buffers returned words in a small prefetch FIFO for the ID stage.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        W_PC,
    input  logic        S_MXPC,
    input  logic [31:0] target,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] WPC,
    output logic        inst_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [31:0]   r_word [DEPTH];
    logic [31:0]   r_wpc  [DEPTH];

    logic          w_redirect;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_after_pop;
    logic          w_issue_ok;
    logic          w_chain_ok;
    logic [31:0]   w_next_pc;

    assign inst_valid  = (r_count != '0);
    assign w_redirect  = W_PC & S_MXPC;
    assign w_pop       = inst_valid & id_ready;
    assign w_push      = (r_state == S_WAIT) & imem_ack & ~w_redirect;
    assign w_after_pop = 32'(r_count) - {31'b0, w_pop};
    // A slot is reserved at issue time, so a push can never overflow.
    assign w_issue_ok  = w_after_pop < 32'(DEPTH);
    assign w_chain_ok  = (w_after_pop + 32'd1) < 32'(DEPTH);
    assign w_next_pc   = r_fetch_pc + PC_STEP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
        end else begin
            if (w_redirect) begin
                r_count    <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
                r_fetch_pc <= target;
            end else begin
                r_count <= CW'(w_after_pop + {31'b0, w_push});
                if (w_pop)
                    r_rd <= r_rd + 1'b1;
                if (w_push) begin
                    r_wr       <= r_wr + 1'b1;
                    r_fetch_pc <= w_next_pc;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_redirect && w_issue_ok) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        if (!w_redirect && w_chain_ok) begin
                            r_addr <= w_next_pc;
                        end else begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end else if (w_redirect) begin
                        // Request stays up; its data is thrown away.
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_word[r_wr] <= imem_rdata;
            r_wpc[r_wr]  <= r_addr + PC_STEP;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = inst_valid ? r_word[r_rd] : 32'h0;
    assign WPC         = inst_valid ? r_wpc[r_rd]  : 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory answers 0x100+addr, expected
// values are hand-computed per cycle and sampled on the falling edge.
module tb_if_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        W_PC;
    logic        S_MXPC;
    logic [31:0] target;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] WPC;
    logic        inst_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign imem_rdata = imem_addr + 32'h100;

    if_fetch #(
        .RESET_PC(32'h0),
        .PC_STEP (32'd1),
        .DEPTH   (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .W_PC       (W_PC),
        .S_MXPC     (S_MXPC),
        .target     (target),
        .id_ready   (id_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .WPC        (WPC),
        .inst_valid (inst_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic redirect(input logic [31:0] t);
        W_PC   = 1'b1;
        S_MXPC = 1'b1;
        target = t;
    endtask

    task automatic no_redirect();
        W_PC   = 1'b0;
        S_MXPC = 1'b0;
        target = 32'h0;
    endtask

    initial begin
        RST = 1'b1; no_redirect(); id_ready = 1'b1; imem_ack = 1'b1;

        // reset then sequential, zero-wait
        step();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_wpc", WPC, 32'h0);
        RST = 1'b0;
        step();
        check("seq_req", {31'b0, imem_req}, 32'd1);
        check("seq_addr0", imem_addr, 32'h0);
        check("seq_valid0", {31'b0, inst_valid}, 32'd0);
        step();
        check("seq_i0", instruction, 32'h100);
        check("seq_w0", WPC, 32'h1);
        W_PC = 1'b1; target = 32'h40;
        step();
        check("seq_i1", instruction, 32'h101);
        check("seq_w1", WPC, 32'h2);
        no_redirect();
        step();
        check("seq_i2", instruction, 32'h102);
        check("seq_w2", WPC, 32'h3);

        // backpressure
        RST = 1'b1; id_ready = 1'b0;
        step();
        RST = 1'b0;
        step();
        step();
        step();
        check("bp_req_off", {31'b0, imem_req}, 32'd0);
        check("bp_head", instruction, 32'h100);
        step();
        step();
        check("bp_req_hold", {31'b0, imem_req}, 32'd0);
        check("bp_head_hold", instruction, 32'h100);
        id_ready = 1'b1;
        step();
        check("bp_i1", instruction, 32'h101);
        check("bp_w1", WPC, 32'h2);
        check("bp_reissue", imem_addr, 32'h2);
        step();
        check("bp_i2", instruction, 32'h102);

        // wait states
        RST = 1'b1; imem_ack = 1'b0;
        step();
        RST = 1'b0;
        step();
        check("ws_addr_c1", imem_addr, 32'h0);
        step();
        check("ws_addr_c2", imem_addr, 32'h0);
        check("ws_req_c2", {31'b0, imem_req}, 32'd1);
        step();
        check("ws_addr_c3", imem_addr, 32'h0);
        check("ws_valid_c3", {31'b0, inst_valid}, 32'd0);
        imem_ack = 1'b1;
        step();
        check("ws_push", instruction, 32'h100);
        check("ws_next_addr", imem_addr, 32'h1);
        imem_ack = 1'b0;
        step();
        check("ws_one_push", {31'b0, inst_valid}, 32'd0);
        check("ws_addr_hold", imem_addr, 32'h1);

        // redirect in WAIT without ack
        redirect(32'h40);
        step();
        no_redirect();
        check("dr_req_held", {31'b0, imem_req}, 32'd1);
        check("dr_addr_held", imem_addr, 32'h1);
        imem_ack = 1'b1;
        step();
        check("dr_req_off", {31'b0, imem_req}, 32'd0);
        check("dr_dropped", {31'b0, inst_valid}, 32'd0);
        step();
        check("dr_tgt_addr", imem_addr, 32'h40);
        check("dr_tgt_req", {31'b0, imem_req}, 32'd1);
        step();
        check("dr_tgt_i", instruction, 32'h140);
        check("dr_tgt_w", WPC, 32'h41);

        // redirect with ack in WAIT, FIFO non-empty
        id_ready = 1'b0;
        redirect(32'h80);
        step();
        no_redirect();
        check("ra_flush", {31'b0, inst_valid}, 32'd0);
        check("ra_instr0", instruction, 32'h0);
        check("ra_req_off", {31'b0, imem_req}, 32'd0);
        step();
        check("ra_tgt_addr", imem_addr, 32'h80);
        id_ready = 1'b1;

        // reset mid-transaction
        RST = 1'b1;
        step();
        check("mr_req", {31'b0, imem_req}, 32'd0);
        check("mr_addr", imem_addr, 32'h0);
        check("mr_valid", {31'b0, inst_valid}, 32'd0);
        RST = 1'b0;
        imem_ack = 1'b0;
        step();
        check("mr_reissue", imem_addr, 32'h0);

        // PC wrap
        redirect(32'hFFFF_FFFF);
        step();
        no_redirect();
        imem_ack = 1'b1;
        step();
        step();
        check("wr_addr", imem_addr, 32'hFFFF_FFFF);
        step();
        check("wr_valid", {31'b0, inst_valid}, 32'd1);
        check("wr_instr", instruction, 32'h0000_00FF);
        check("wr_wpc", WPC, 32'h0);
        check("wr_next_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that feeds the ID stage. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Fetched words are buffered in a small prefetch FIFO and presented to ID as `instruction` plus `WPC`, the return address PC+PC_STEP. ID's `W_PC`/`S_MXPC` redirect the stream on taken branches: the FIFO is flushed and stale in-flight data is discarded.

## Interface
- RESET_PC, 32'h0, fetch address loaded on reset
- PC_STEP, 1, PC increment per instruction (word addressing)
- DEPTH, 2, prefetch FIFO entries (2 or 4)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- W_PC  in  1  PC write enable from ID
- S_MXPC  in  1  PC mux select from ID; redirect = W_PC & S_MXPC
- target  in  32  redirect address, valid when redirect=1
- id_ready  in  1  ID consumes FIFO head this cycle when inst_valid=1
- imem_req  out  1  memory read request, registered
- imem_addr  out  32  read address, registered, stable while imem_req=1
- imem_ack  in  1  read complete; imem_rdata valid same cycle
- imem_rdata  in  32  read data
- instruction  out  32  FIFO head word; 0 when empty
- WPC  out  32  FIFO head fetch address + PC_STEP; 0 when empty
- inst_valid  out  1  FIFO non-empty

## Operation
- State: fetch_pc (next address to request), FSM {IDLE, WAIT, DROP}, FIFO of {word, addr+PC_STEP}, count 0..DEPTH.
- pop = inst_valid & id_ready. push = ack accepted in WAIT with no redirect.
- IDLE: if count-pop < DEPTH and no redirect -> WAIT, imem_req<=1, imem_addr<=fetch_pc.
- WAIT, imem_ack=1, no redirect: push {imem_rdata, imem_addr+PC_STEP}; fetch_pc += PC_STEP. If count+1-pop < DEPTH, stay WAIT with imem_addr<=new fetch_pc (back-to-back); else -> IDLE, imem_req<=0.
- WAIT, imem_ack=0: hold imem_req and imem_addr unchanged.
- Handshake rule: once raised, imem_req stays high with stable imem_addr until imem_ack. A request is never withdrawn.
- Redirect has priority over push and pop. Effects:
  - flush FIFO (count<=0);
  - fetch_pc<=target.
  - IDLE -> IDLE.
  - WAIT with ack -> IDLE; data discarded, imem_req<=0.
  - WAIT without ack -> DROP; request held.
  - DROP without ack: stay DROP; latest target wins.
  - DROP with ack -> IDLE.
- DROP: on imem_ack, discard data -> IDLE, imem_req<=0. Never pushes.
- W_PC=1 with S_MXPC=0 has no effect; sequential fetch is autonomous.
- Push only occurs when a slot was reserved at issue, so FIFO overflow is impossible. A pop on empty is ignored.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32: 32'hFFFF_FFFF + 1 = 0.

## Timing
- Reset values, one edge with RST=1:
  - FSM=IDLE, fetch_pc=RESET_PC, count=0;
  - imem_req=0, imem_addr=RESET_PC;
  - inst_valid=0, instruction=0, WPC=0.
- RST=1 mid-transaction forces the reset state regardless of imem_ack. No push occurs in that cycle.
- First imem_req=1 one cycle after RST deasserts.
- Pushed entry appears on the outputs the cycle after the ack edge; there is no bypass.
- With zero-wait memory (ack tied 1) and id_ready=1: one instruction per cycle sustained.
- After redirect: inst_valid=0 the next cycle. The first target word is requested the cycle after returning to IDLE.
- instruction, WPC and inst_valid are driven from registered FIFO state only. No combinational path from inputs.

## Test plan
- Reset then sequential: RESET_PC=0, ack tied 1, id_ready=1, memory returns 0x100+addr -> instruction=0x100,0x101,0x102 on consecutive cycles with WPC=1,2,3.
- Backpressure: id_ready=0, DEPTH=2 -> exactly 2 pushes, then imem_req=0. Releasing id_ready delivers 0x100, 0x101 in order, no duplicate or loss.
- Wait states: ack asserted 3 cycles after req -> imem_addr constant across all 3 cycles, one push per ack.
- Redirect during WAIT (no ack), target=0x40: the next ack is dropped, the FIFO empties, the next request has imem_addr=0x40, and the first delivered word has WPC=0x41.
- Redirect and ack in the same cycle in WAIT -> data discarded, inst_valid=0 next cycle, next request to target.
- RST asserted while imem_req=1 -> next cycle imem_req=0, imem_addr=RESET_PC, inst_valid=0. PC wrap: target=32'hFFFF_FFFF -> WPC=0, next imem_addr=0.
